seg_src_sched: RTL

Time-multiplexing scheduler for the 6-digit seven-segment display path. Up to N_SRC producers share the single 20-bit `dout` input of `seg_ctrl`: for example the DS18B20 temperature reading, the alarm threshold and a status code. The block grants the display to one requester at a time, round-robin, and holds each grant for a minimum dwell time. It sits between the producers and `seg_ctrl`.

---
 rtl/seg_pkg.sv | 12 +
 rtl/seg_src_sched_rr_pick.sv | 27 ++
 rtl/seg_src_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display source path.
package seg_pkg;

  typedef enum logic {
    IDLE,
    SHOW
  } seg_state_t;

  localparam int unsigned SEG_DW = 20;
  localparam logic [SEG_DW-1:0] SEG_BLANK_VAL = 20'hFFFFF;

endpackage

// File: rtl/seg_src_sched_rr_pick.sv
// Combinational round-robin picker: first requester found after index `last`.
module seg_rr_pick #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned LW    = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [N_SRC-1:0] pick,
  output logic             found
);

  logic [LW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = LW'((32'(last) + 32'd1 + k) % N_SRC);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_src_sched.sv
// Round-robin time-multiplexing scheduler feeding seg_ctrl with a minimum dwell per grant.
// Optional alarm preemption by source 0 when SEG_SRC_SCHED_ALARM_PREEMPT_EN is defined.
module seg_src_sched
  import seg_pkg::*;
#(
  parameter int unsigned      N_SRC     = 3,
  parameter int unsigned      DW        = SEG_DW,
  parameter int unsigned      HOLD_CYC  = 50_000_000,
  parameter logic [DW-1:0]    BLANK_VAL = SEG_BLANK_VAL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    req,
  input  logic [N_SRC*DW-1:0] src_data,
  output logic [DW-1:0]       dout,
  output logic                dout_vld,
  output logic [N_SRC-1:0]    grant
);

  localparam int unsigned LW = $clog2(N_SRC);
  localparam int unsigned CW = $clog2(HOLD_CYC);
  localparam logic [N_SRC-1:0] SRC0 = N_SRC'(1);

  seg_state_t       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [LW-1:0]    last, last_nxt;
  logic [N_SRC-1:0] grant_nxt;
  logic [DW-1:0]    data_nxt;

  logic [LW-1:0]    own_idx;
  logic [N_SRC-1:0] pick_req, pick;
  logic [LW-1:0]    pick_last;
  logic             found, owner_req, expired;
  logic             alarm_take, alarm_hold;

  always_comb begin
    own_idx = '0;
    for (int unsigned i = 0; i < N_SRC; i++)
      if (grant[i]) own_idx = LW'(i);
  end

  // While showing, the picker excludes the owner and searches from it, so one
  // instance serves idle arbitration, expiry rotation and drop-out handover.
  assign pick_req  = (state == SHOW) ? (req & ~grant) : req;
  assign pick_last = (state == SHOW) ? own_idx : last;

  seg_rr_pick #(
    .N_SRC (N_SRC),
    .LW    (LW)
  ) u_pick (
    .req   (pick_req),
    .last  (pick_last),
    .pick  (pick),
    .found (found)
  );

  assign owner_req = |(req & grant);
  assign expired   = (cnt == CW'(HOLD_CYC - 1));

`ifdef SEG_SRC_SCHED_ALARM_PREEMPT_EN
  assign alarm_take = req[0] & ~grant[0];
  assign alarm_hold = grant[0];
`else
  assign alarm_take = 1'b0;
  assign alarm_hold = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (alarm_take) begin
          state_nxt = SHOW;
          grant_nxt = SRC0;
          cnt_nxt   = '0;
        end else if (found) begin
          state_nxt = SHOW;
          grant_nxt = pick;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (alarm_take) begin
          grant_nxt = SRC0;
          cnt_nxt   = '0;
        end else if (!owner_req) begin
          if (found) begin
            grant_nxt = pick;
            last_nxt  = own_idx;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            cnt_nxt   = '0;
          end
        end else if (expired) begin
          cnt_nxt = '0;
          if (found && !alarm_hold) begin
            grant_nxt = pick;
            last_nxt  = own_idx;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    data_nxt = '0;
    for (int unsigned i = 0; i < N_SRC; i++)
      if (grant_nxt[i]) data_nxt = data_nxt | src_data[i*DW +: DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= LW'(N_SRC - 1);
      grant    <= '0;
      dout_vld <= 1'b0;
      dout     <= BLANK_VAL;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      grant    <= grant_nxt;
      dout_vld <= (state_nxt == SHOW);
      dout     <= (state_nxt == SHOW) ? data_nxt : BLANK_VAL;
    end
  end

endmodule
